// File: rtl/pipe_bigadd_pkg.sv
// Shared helpers for the pipelined wide adder.
//   params_ok : elaboration-time legality check for (DW, NSTAGES).
package pipe_bigadd_pkg;

  function automatic bit params_ok(int dw, int ns);
    if (ns < 1) return 1'b0;
    if (ns > dw) return 1'b0;
    return (dw % ns) == 0;
  endfunction

endpackage

// File: rtl/pipe_bigadd_seg.sv
// One SW-bit ripple segment of the pipelined adder, fully registered.
// Ports:
//   i_clk, i_areset_n : clock, async active-low reset
//   i_ce              : advance enable; state holds when low
//   i_a, i_b, i_cin   : segment operands (b already inverted for subtract)
//   o_sum             : registered segment sum
//   o_cout            : registered carry out of the segment MSB
//   o_ovf             : registered (carry into MSB ^ carry out of MSB); only
//                       meaningful as signed overflow for the top segment
module pipe_bigadd_seg #(
  parameter int SW = 32
) (
  input  logic          i_clk,
  input  logic          i_areset_n,
  input  logic          i_ce,
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_cin,
  output logic [SW-1:0] o_sum,
  output logic          o_cout,
  output logic          o_ovf
);

  logic [SW:0] s;
  logic        cmsb;

  // Carry into the MSB is recovered from the sum bit, which also works for SW=1.
  always_comb begin
    s    = {1'b0, i_a} + {1'b0, i_b} + {{SW{1'b0}}, i_cin};
    cmsb = s[SW-1] ^ i_a[SW-1] ^ i_b[SW-1];
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      o_sum  <= '0;
      o_cout <= 1'b0;
      o_ovf  <= 1'b0;
    end else if (i_ce) begin
      o_sum  <= s[SW-1:0];
      o_cout <= s[SW];
      o_ovf  <= s[SW] ^ cmsb;
    end
  end

endmodule

// File: rtl/pipe_bigadd.sv
// Parametrised pipelined DW-bit add/subtract. The operand is split into
// NSTAGES segments of SW bits; segment j is delayed j cycles before its adder
// and its sum is delayed NSTAGES-1-j cycles afterwards so all bits exit
// together. Latency NSTAGES enabled cycles, throughput one per enabled cycle.
// Ports:
//   i_clk, i_areset_n : clock, async active-low reset
//   i_ce              : pipeline advance enable
//   i_sync            : tag aligned with the result at o_sync
//   i_sub, i_cin      : 0 add / 1 subtract; carry-in (borrow-in when subtracting)
//   i_a, i_b          : operands
//   o_r, o_cout, o_ovf: result, carry out of MSB, signed overflow
//   o_sync            : delayed tag
module pipe_bigadd
  import pipe_bigadd_pkg::*;
#(
  parameter int DW      = 64,
  parameter int NSTAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_areset_n,
  input  logic          i_ce,
  input  logic          i_sync,
  input  logic          i_sub,
  input  logic          i_cin,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_r,
  output logic          o_cout,
  output logic          o_ovf,
  output logic          o_sync
);

  // NS guards the divide so an illegal NSTAGES reaches the check below.
  localparam int NS = (NSTAGES < 1) ? 1 : NSTAGES;
  localparam int SW = DW / NS;

  if (!params_ok(DW, NSTAGES)) begin : g_bad_params
    $error("pipe_bigadd: DW must be a multiple of NSTAGES with 1 <= NSTAGES <= DW");
  end

  logic [DW-1:0] b_eff;
  logic          cin_eff;
  logic [NS-1:0] cy, ov, top_seg, sync_q;

  assign b_eff   = i_sub ? ~i_b : i_b;
  assign cin_eff = i_sub ? ~i_cin : i_cin;

  for (genvar j = 0; j < NS; j++) begin : g_seg
    logic [SW-1:0] a_use, b_use, sum, res;
    logic          c_use;

    if (j == 0) begin : g_nd
      assign a_use = i_a[SW-1:0];
      assign b_use = b_eff[SW-1:0];
      assign c_use = cin_eff;
    end else begin : g_sk
      // Operand skew: a_d[j-1] is the segment sampled j enabled cycles ago.
      logic [j-1:0][SW-1:0] a_d, b_d;
      always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
          a_d <= '0;
          b_d <= '0;
        end else if (i_ce) begin
          a_d[0] <= i_a[j*SW +: SW];
          b_d[0] <= b_eff[j*SW +: SW];
          for (int i = 1; i < j; i++) begin
            a_d[i] <= a_d[i-1];
            b_d[i] <= b_d[i-1];
          end
        end
      end
      assign a_use = a_d[j-1];
      assign b_use = b_d[j-1];
      assign c_use = cy[j-1];
    end

    pipe_bigadd_seg #(.SW(SW)) u_seg (
      .i_clk      (i_clk),
      .i_areset_n (i_areset_n),
      .i_ce       (i_ce),
      .i_a        (a_use),
      .i_b        (b_use),
      .i_cin      (c_use),
      .o_sum      (sum),
      .o_cout     (cy[j]),
      .o_ovf      (ov[j])
    );

    if (j == NS-1) begin : g_nr
      assign res = sum;
    end else begin : g_rs
      // Result deskew: finished low segments wait for the top segment.
      logic [NS-2-j:0][SW-1:0] r_d;
      always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
          r_d <= '0;
        end else if (i_ce) begin
          r_d[0] <= sum;
          for (int i = 1; i <= NS-2-j; i++) r_d[i] <= r_d[i-1];
        end
      end
      assign res = r_d[NS-2-j];
    end

    assign o_r[j*SW +: SW] = res;
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      sync_q <= '0;
    end else if (i_ce) begin
      sync_q[0] <= i_sync;
      for (int i = 1; i < NS; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Only the top segment's overflow is a signed overflow of the whole word.
  always_comb begin
    top_seg       = '0;
    top_seg[NS-1] = 1'b1;
  end

  assign o_cout = cy[NS-1];
  assign o_ovf  = |(ov & top_seg);
  assign o_sync = sync_q[NS-1];

endmodule

// File: tb/tb_pipe_bigadd.sv
module tb_pipe_bigadd;

  typedef struct packed {
    logic [95:0] r;
    logic        cout;
    logic        ovf;
    logic        sync;
  } exp_t;

  typedef struct {
    logic [63:0] a, b;
    logic        sub, cin, sync;
    logic [63:0] r;
    logic        cout, ovf;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ce, sub, cin, sync;
  logic [63:0] a, b, r;
  logic        cout, ovf, osync;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];

  pipe_bigadd #(.DW(64), .NSTAGES(2)) u_dut (
    .i_clk(clk), .i_areset_n(rst_n), .i_ce(ce), .i_sync(sync), .i_sub(sub),
    .i_cin(cin), .i_a(a), .i_b(b), .o_r(r), .o_cout(cout), .o_ovf(ovf),
    .o_sync(osync)
  );

  // Parameter sweep instances
  localparam int SDW[4] = '{64, 64, 96, 8};
  localparam int SNS[4] = '{1, 4, 3, 8};

  logic [95:0] sa[4], sb[4], sr[4];
  logic        ssub[4], scin[4], ssync[4], scout[4], sovf[4], sosync[4];
  exp_t        sq[4][$];

  for (genvar k = 0; k < 4; k++) begin : g_sw
    pipe_bigadd #(.DW(SDW[k]), .NSTAGES(SNS[k])) u_dut (
      .i_clk(clk), .i_areset_n(rst_n), .i_ce(ce), .i_sync(ssync[k]),
      .i_sub(ssub[k]), .i_cin(scin[k]),
      .i_a(sa[k][SDW[k]-1:0]), .i_b(sb[k][SDW[k]-1:0]),
      .o_r(sr[k][SDW[k]-1:0]), .o_cout(scout[k]), .o_ovf(sovf[k]),
      .o_sync(sosync[k])
    );
  end

  function automatic logic [95:0] wmask(int dw);
    return (96'd1 << dw) - 96'd1;
  endfunction

  // Reference: plain full-width add of the effective operands.
  function automatic exp_t model(int dw, logic [95:0] ma, logic [95:0] mb,
                                 logic msub, logic mcin, logic msync);
    logic [96:0] full;
    logic [95:0] m, am, bx;
    logic        c, cm;
    exp_t        e;
    m    = wmask(dw);
    am   = ma & m;
    bx   = (msub ? ~mb : mb) & m;
    c    = msub ? ~mcin : mcin;
    full = {1'b0, am} + {1'b0, bx} + {96'd0, c};
    e.r    = full[95:0] & m;
    e.cout = full[dw];
    cm     = full[dw-1] ^ am[dw-1] ^ bx[dw-1];
    e.ovf  = e.cout ^ cm;
    e.sync = msync;
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_zero;
    a = '0; b = '0; sub = 0; cin = 0; sync = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; ce = 0; drive_zero();
    for (int k = 0; k < 4; k++) begin
      sa[k] = '0; sb[k] = '0; ssub[k] = 0; scin[k] = 0; ssync[k] = 0;
    end
    #12;
    n_cmp++;
    if (r !== 64'd0) begin n_bad++; $display("FAIL reset_r: got %h want 0", r); end
    n_cmp++;
    if ({cout, ovf, osync} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {cout, ovf, osync});
    end
    @(negedge clk);
    rst_n = 1; ce = 1;
    tick(); tick();
    n_cmp++;
    if ({r, osync} !== 65'd0) begin
      n_bad++; $display("FAIL reset_release: got r=%h sync=%b want 0/0", r, osync);
    end
  endtask

  task automatic test_directed;
    vec_t tv[8];
    exp_t e;
    tv[0] = '{64'h00000000_FFFFFFFF, 64'd1, 0, 0, 1, 64'h00000001_00000000, 0, 0};
    tv[1] = '{64'd0, 64'd1, 1, 0, 0, 64'hFFFFFFFF_FFFFFFFF, 0, 0};
    tv[2] = '{64'h80000000_00000000, 64'd1, 1, 0, 1, 64'h7FFFFFFF_FFFFFFFF, 1, 1};
    tv[3] = '{64'h7FFFFFFF_FFFFFFFF, 64'd1, 0, 0, 0, 64'h80000000_00000000, 0, 1};
    tv[4] = '{64'hFFFFFFFF_FFFFFFFF, 64'd0, 0, 1, 1, 64'd0, 1, 0};
    tv[5] = '{64'hFFFFFFFF_FFFFFFFF, 64'd1, 0, 0, 0, 64'd0, 1, 0};
    tv[6] = '{64'd10, 64'd3, 1, 1, 1, 64'd6, 1, 0};
    tv[7] = '{64'h00000000_FFFFFFFF, 64'hFFFFFFFF_00000000, 0, 0, 1,
              64'hFFFFFFFF_FFFFFFFF, 0, 0};
    q.delete();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        a = tv[i].a; b = tv[i].b; sub = tv[i].sub; cin = tv[i].cin; sync = tv[i].sync;
        q.push_back('{{32'd0, tv[i].r}, tv[i].cout, tv[i].ovf, tv[i].sync});
      end else begin
        drive_zero();
        q.push_back('0);
      end
      tick();
      if (q.size() == 2) begin
        e = q.pop_front();
        n_cmp++;
        if ({r, cout, ovf, osync} !== {e.r[63:0], e.cout, e.ovf, e.sync}) begin
          n_bad++;
          $display("FAIL directed: got r=%h c=%b o=%b s=%b want r=%h c=%b o=%b s=%b",
                   r, cout, ovf, osync, e.r[63:0], e.cout, e.ovf, e.sync);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t        e;
    logic [63:0] held_r;
    logic        held_s;
    q.delete();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        held_r = r; held_s = osync;
        ce = 0;
        for (int s = 0; s < 3; s++) begin
          a = {$urandom, $urandom}; b = {$urandom, $urandom};
          sync = ~sync; sub = $urandom_range(0, 1);
          tick();
          n_cmp++;
          if ({r, osync} !== {held_r, held_s}) begin
            n_bad++;
            $display("FAIL stall_hold: got r=%h s=%b want r=%h s=%b", r, osync, held_r, held_s);
          end
        end
        ce = 1;
      end
      if (i < 8) begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        sub = $urandom_range(0, 1); cin = $urandom_range(0, 1); sync = i[0];
      end else begin
        drive_zero();
      end
      q.push_back(model(64, {32'd0, a}, {32'd0, b}, sub, cin, sync));
      tick();
      if (q.size() == 2) begin
        e = q.pop_front();
        n_cmp++;
        if ({r, cout, ovf, osync} !== {e.r[63:0], e.cout, e.ovf, e.sync}) begin
          n_bad++;
          $display("FAIL back_to_back: got r=%h c=%b o=%b s=%b want r=%h c=%b o=%b s=%b",
                   r, cout, ovf, osync, e.r[63:0], e.cout, e.ovf, e.sync);
        end
      end
    end
  endtask

  task automatic test_reset_midflight;
    q.delete();
    ce = 1;
    a = 64'd100; b = 64'd1; sub = 0; cin = 0; sync = 1;
    tick();
    a = 64'd5; b = 64'd7; sync = 1;
    tick();
    n_cmp++;
    if ({r, osync} !== {64'd101, 1'b1}) begin
      n_bad++; $display("FAIL midflight_pre: got r=%h s=%b want r=65 s=1", r, osync);
    end
    drive_zero();
    #1 rst_n = 0;
    #1;
    n_cmp++;
    if ({r, cout, ovf, osync} !== 67'd0) begin
      n_bad++;
      $display("FAIL midflight_async: got r=%h c=%b o=%b s=%b want all 0", r, cout, ovf, osync);
    end
    #1 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({r, osync} !== 65'd0) begin
        n_bad++; $display("FAIL midflight_discard: got r=%h s=%b want r=0 s=0", r, osync);
      end
    end
  endtask

  task automatic test_sweep;
    exp_t        e;
    logic [95:0] m;
    ce = 1;
    for (int k = 0; k < 4; k++) sq[k].delete();
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 4; k++) begin
        m = wmask(SDW[k]);
        sa[k] = (i % 5 == 0) ? m : ({$urandom, $urandom, $urandom} & m);
        sb[k] = (i % 10 == 0) ? 96'd1 : ({$urandom, $urandom, $urandom} & m);
        ssub[k] = $urandom_range(0, 1);
        scin[k] = $urandom_range(0, 1);
        ssync[k] = $urandom_range(0, 1);
        sq[k].push_back(model(SDW[k], sa[k], sb[k], ssub[k], scin[k], ssync[k]));
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        if (sq[k].size() == SNS[k]) begin
          e = sq[k].pop_front();
          m = wmask(SDW[k]);
          n_cmp++;
          if ({sr[k] & m, scout[k], sovf[k], sosync[k]} !== {e.r, e.cout, e.ovf, e.sync}) begin
            n_bad++;
            $display("FAIL sweep_dw%0d_ns%0d: got r=%h c=%b o=%b s=%b want r=%h c=%b o=%b s=%b",
                     SDW[k], SNS[k], sr[k] & m, scout[k], sovf[k], sosync[k],
                     e.r, e.cout, e.ovf, e.sync);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
